// File: rtl/ssd_pkg.sv
// Shared constants and the hex-to-segment table for the seven-segment scan controller.
// Leading-zero blanking in ssd_scan_ctrl is built only when SSD_LZB_EN is defined.
package ssd_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] ANODE_OFF = 8'hFF;

    // Segment order abcdefg, a 0 lights the segment.
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational 4-bit nibble to active-low abcdefg segment decoder.
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = hex_seg(nibble);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// N-digit seven-segment scanner with ghost blanking and frame-aligned loads.
// Optional leading-zero blanking is enabled by defining SSD_LZB_EN.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int PRESCALE_BITS = 18,
    parameter int GHOST_CYCLES  = 1024
) (
    input  logic                    ClkPort,
    input  logic                    Reset_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   An,
    output logic [7:0]              cathodes,
    output logic                    frame_tick
);

    localparam int                       IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRESCALE_BITS-1:0] GHOST_LIM = PRESCALE_BITS'(GHOST_CYCLES);
    localparam logic [NUM_DIGITS-1:0]    AN_OFF    = ANODE_OFF[NUM_DIGITS-1:0];

    logic [PRESCALE_BITS-1:0] prescale_r;
    logic [IDX_W-1:0]         index_r;
    logic [4*NUM_DIGITS-1:0]  value_act_r, value_pend_r;
    logic [NUM_DIGITS-1:0]    dp_act_r, dp_pend_r, en_act_r, en_pend_r;
    logic                     pending_r, load_ready_r;
    logic [NUM_DIGITS-1:0]    an_r;
    logic [7:0]               cath_r;
    logic                     frame_tick_r;

    logic                     terminal_s, boundary_s, accept_s;
    logic [3:0]               nibble_s;
    logic [6:0]               seg_s;
    logic [NUM_DIGITS-1:0]    lz_mask_s;
    logic                     zero_run_s;
    logic                     blank_s;
    logic [NUM_DIGITS-1:0]    an_nxt_s;
    logic [7:0]               cath_nxt_s;

    assign terminal_s = &prescale_r;
    assign boundary_s = terminal_s && (index_r == LAST_IDX);
    assign accept_s   = load_valid && load_ready_r;
    assign nibble_s   = value_act_r[{index_r, 2'b00} +: 4];

    ssd_hex_decode u_hex_decode (
        .nibble   (nibble_s),
        .segments (seg_s)
    );

`ifdef SSD_LZB_EN
    // A digit above 0 is a leading zero when it and every higher nibble are zero.
    always_comb begin
        lz_mask_s  = '0;
        zero_run_s = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run_s   = zero_run_s & (value_act_r[4*i +: 4] == 4'h0);
            lz_mask_s[i] = zero_run_s;
        end
    end
`else
    assign lz_mask_s  = '0;
    assign zero_run_s = 1'b0;
`endif

    // Next anode/cathode pattern from the current scan state.
    always_comb begin
        an_nxt_s   = AN_OFF;
        cath_nxt_s = SEG_BLANK;
        blank_s    = (prescale_r < GHOST_LIM) || !en_act_r[index_r] || lz_mask_s[index_r];
        if (blank_s) begin
            an_nxt_s   = AN_OFF;
            cath_nxt_s = SEG_BLANK;
        end else begin
            an_nxt_s   = ~(NUM_DIGITS'(1) << index_r);
            cath_nxt_s = {seg_s, ~dp_act_r[index_r]};
        end
    end

    // Slot prescaler and digit index.
    always_ff @(posedge ClkPort) begin
        if (!Reset_n) begin
            prescale_r <= '0;
            index_r    <= '0;
        end else begin
            prescale_r <= prescale_r + PRESCALE_BITS'(1);
            if (terminal_s) begin
                index_r <= (index_r == LAST_IDX) ? '0 : index_r + IDX_W'(1);
            end
        end
    end

    // Load handshake: capture into pending, promote to active only at a frame boundary.
    always_ff @(posedge ClkPort) begin
        if (!Reset_n) begin
            value_act_r  <= '0;
            dp_act_r     <= '0;
            en_act_r     <= '0;
            value_pend_r <= '0;
            dp_pend_r    <= '0;
            en_pend_r    <= '0;
            pending_r    <= 1'b0;
            load_ready_r <= 1'b1;
        end else if (accept_s) begin
            value_pend_r <= value;
            dp_pend_r    <= dp;
            en_pend_r    <= digit_en;
            pending_r    <= 1'b1;
            load_ready_r <= 1'b0;
        end else if (boundary_s && pending_r) begin
            value_act_r  <= value_pend_r;
            dp_act_r     <= dp_pend_r;
            en_act_r     <= en_pend_r;
            pending_r    <= 1'b0;
            load_ready_r <= 1'b1;
        end
    end

    // Registered pin drivers, one clock behind the scan state.
    always_ff @(posedge ClkPort) begin
        if (!Reset_n) begin
            an_r         <= AN_OFF;
            cath_r       <= SEG_BLANK;
            frame_tick_r <= 1'b0;
        end else begin
            an_r         <= an_nxt_s;
            cath_r       <= cath_nxt_s;
            frame_tick_r <= boundary_s;
        end
    end

    assign load_ready = load_ready_r;
    assign An         = an_r;
    assign cathodes   = cath_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with NUM_DIGITS=4, PRESCALE_BITS=3, GHOST_CYCLES=1.
// Expectations follow SSD_LZB_EN when the bundle is compiled with it defined.
module tb_ssd_scan_ctrl;

    localparam int ND = 4;
    localparam int PB = 3;
    localparam int GC = 1;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic [3:0]      en;
        logic [3:0][7:0] ec;   // expected cathodes per slot, 8'hFF means blanked
    } vec_t;

    logic        ClkPort = 1'b0;
    logic        Reset_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  digit_en = 4'h0;
    logic [3:0]  An;
    logic [7:0]  cathodes;
    logic        frame_tick;

    int   k = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[5];

    ssd_scan_ctrl #(.NUM_DIGITS(ND), .PRESCALE_BITS(PB), .GHOST_CYCLES(GC)) dut (
        .ClkPort    (ClkPort),
        .Reset_n    (Reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .value      (value),
        .dp         (dp),
        .digit_en   (digit_en),
        .An         (An),
        .cathodes   (cathodes),
        .frame_tick (frame_tick)
    );

    always #5 ClkPort = ~ClkPort;

    initial begin
        #200000;
        $display("FAIL watchdog k=%0d got running want finished", k);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge ClkPort);
        k++;
        @(negedge ClkPort);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s k=%0d got %h want %h", nm, k, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_an"},    32'(An),         32'h0000_000F);
        chk({nm, "_cath"},  32'(cathodes),   32'h0000_00FF);
        chk({nm, "_ready"}, 32'(load_ready), 32'h1);
        chk({nm, "_tick"},  32'(frame_tick), 32'h0);
    endtask

    // One full frame starting at slot 0, phase 0.
    task automatic check_frame(input logic [3:0][7:0] ec);
        int          slot;
        int          ph;
        logic [3:0]  one;
        logic [3:0]  exp_an;
        logic [7:0]  exp_c;
        for (int j = 0; j < 32; j++) begin
            step();
            slot = j / 8;
            ph   = j % 8;
            one  = 4'b0001;
            if (ph == 0 || ec[slot] == 8'hFF) begin
                exp_an = 4'hF;
                exp_c  = 8'hFF;
            end else begin
                exp_an = ~(one << slot);
                exp_c  = ec[slot];
            end
            chk("frame_an",   32'(An),         32'(exp_an));
            chk("frame_cath", 32'(cathodes),   32'(exp_c));
            chk("frame_tick", 32'(frame_tick), (j == 31) ? 32'h1 : 32'h0);
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (!frame_tick && n < 40) begin
            step();
            n++;
        end
        chk("tick_seen", 32'(frame_tick), 32'h1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        int n;
        n = 0;
        while (!load_ready && n < 80) begin
            step();
            n++;
        end
        chk("ready_before_load", 32'(load_ready), 32'h1);
        value      = v;
        dp         = d;
        digit_en   = e;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        chk("ready_after_accept", 32'(load_ready), 32'h0);
    endtask

    initial begin
`ifdef SSD_LZB_EN
        vecs[0] = '{16'h0005, 4'b0000, 4'hF, {8'hFF, 8'hFF, 8'hFF, 8'h49}};
        vecs[1] = '{16'h0000, 4'b0000, 4'hF, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
        vecs[3] = '{16'h0300, 4'b0001, 4'hE, {8'hFF, 8'h0D, 8'h03, 8'hFF}};
`else
        vecs[0] = '{16'h0005, 4'b0000, 4'hF, {8'h03, 8'h03, 8'h03, 8'h49}};
        vecs[1] = '{16'h0000, 4'b0000, 4'hF, {8'h03, 8'h03, 8'h03, 8'h03}};
        vecs[3] = '{16'h0300, 4'b0001, 4'hE, {8'h03, 8'h0D, 8'h03, 8'hFF}};
`endif
        vecs[2] = '{16'hD07E, 4'b1001, 4'b1011, {8'h84, 8'hFF, 8'h1F, 8'h60}};
        vecs[4] = '{16'h6489, 4'b1111, 4'hF,    {8'h40, 8'h98, 8'h00, 8'h08}};

        // Reset held for three clocks.
        @(negedge ClkPort);
        for (int i = 0; i < 3; i++) step();
        chk_reset_vals("reset");

        // First load at the first clock out of reset; a second load while pending is ignored.
        Reset_n    = 1'b1;
        k          = -1;
        value      = 16'h12A0;
        dp         = 4'b0100;
        digit_en   = 4'hF;
        load_valid = 1'b1;
        step();
        chk("accept_ready_low", 32'(load_ready), 32'h0);
        chk("empty_an",         32'(An),         32'h0000_000F);
        value = 16'hFFFF;
        dp    = 4'hF;
        for (int j = 1; j < 32; j++) begin
            step();
            chk("empty_an",      32'(An),         32'h0000_000F);
            chk("pending_ready", 32'(load_ready), (j == 31) ? 32'h1 : 32'h0);
            chk("first_tick",    32'(frame_tick), (j == 31) ? 32'h1 : 32'h0);
        end
        load_valid = 1'b0;
        check_frame({8'h9F, 8'h24, 8'h11, 8'h03});
        check_frame({8'h9F, 8'h24, 8'h11, 8'h03});

        // Table of loads, each checked over the frame after it is applied.
        for (int v = 0; v < 5; v++) begin
            do_load(vecs[v].value, vecs[v].dp, vecs[v].en);
            wait_tick();
            check_frame(vecs[v].ec);
        end

        // Accept coinciding with a frame boundary waits for the following boundary.
        while ((k % 32) != 30) step();
        value      = 16'h1111;
        dp         = 4'h0;
        digit_en   = 4'hF;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        chk("edge_accept_ready", 32'(load_ready), 32'h0);
        chk("edge_accept_tick",  32'(frame_tick), 32'h1);
        check_frame(vecs[4].ec);
        chk("edge_ready_back", 32'(load_ready), 32'h1);
        check_frame({8'h9F, 8'h9F, 8'h9F, 8'h9F});

        // Reset during slot 2 with a load pending discards the pending data.
        do_load(16'h8888, 4'hF, 4'hF);
        while ((k % 32) != 18) step();
        Reset_n = 1'b0;
        step();
        chk_reset_vals("midreset");
        Reset_n = 1'b1;
        k       = -1;
        for (int j = 0; j < 64; j++) begin
            step();
            chk("post_reset_an",    32'(An),         32'h0000_000F);
            chk("post_reset_cath",  32'(cathodes),   32'h0000_00FF);
            chk("post_reset_ready", 32'(load_ready), 32'h1);
            chk("post_reset_tick",  32'(frame_tick), ((j % 32) == 31) ? 32'h1 : 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
